// File: rtl/reg_bank.sv
// -----------------------------------------------------------------------------
// reg_bank
//   Register bank for the mini-CPU with two registered read ports and one write
//   port. The read ports supply the ALU operand pair. Write-back arrives over a
//   valid/ready handshake. After every reset an INIT sweep zeroes one entry per
//   cycle. During the sweep the bank is busy and refuses writes and reads.
//   When a write and a read hit the same address on the same edge, the read
//   returns the new data. Optionally, entry 0 is hardwired to zero.
//
// Parameters
//   DATA_W    width of each register
//   ADDR_W    address width, DEPTH = 2**ADDR_W entries
//   ZERO_REG  1: entry 0 reads as 0 and ignores writes; 0: normal entry
//
// Ports
//   clk       in   clock, all state updates on posedge
//   rst_n     in   synchronous active-low reset
//   wr_valid  in   write request
//   wr_ready  out  write can be accepted (RUN state only)
//   wr_addr   in   write destination
//   wr_data   in   write data
//   rd_en     in   read request for both ports
//   rd_addr1  in   port-1 read address
//   rd_addr2  in   port-2 read address
//   q1        out  port-1 read data, registered
//   q2        out  port-2 read data, registered
//   rd_valid  out  q1/q2 were updated on the previous edge
//   busy      out  INIT sweep in progress
// -----------------------------------------------------------------------------
module reg_bank #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] q1,
  output logic [DATA_W-1:0] q2,
  output logic              rd_valid,
  output logic              busy
);

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam bit                ZERO_EN = (ZERO_REG != 0);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_clr_ptr;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_wr_fire;
  logic              w_wr_keep;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;

  logic [ADDR_W-1:0] w_rd_addr [2];
  logic [DATA_W-1:0] w_rd_data [2];
  logic [DATA_W-1:0] r_q       [2];
  logic              r_rd_valid;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state. INIT covers clr_ptr = 0 .. DEPTH-1, exactly DEPTH cycles.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_INIT:  if (r_clr_ptr == LAST) w_state_next = S_RUN;
      S_RUN:   w_state_next = S_RUN;
      default: w_state_next = S_INIT;
    endcase
  end

  // FSM: outputs, decoded purely from the current state
  always_comb begin
    busy     = 1'b0;
    wr_ready = 1'b0;
    case (r_state)
      S_INIT:  busy     = 1'b1;
      S_RUN:   wr_ready = 1'b1;
      default: busy     = 1'b1;
    endcase
  end

  // Clear pointer. It wraps after the sweep, and nothing looks at it in RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clr_ptr <= '0;
    end else if (r_state == S_INIT) begin
      r_clr_ptr <= r_clr_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Write path. The reset cycle blocks writes even though wr_ready may still
  // show RUN. A write to a hardwired-zero entry 0 is accepted but discarded,
  // so the handshake still completes.
  // ---------------------------------------------------------------------------
  assign w_wr_fire = rst_n && wr_valid && wr_ready;
  assign w_wr_keep = w_wr_fire && !(ZERO_EN && (wr_addr == '0));

  // The INIT sweep and write-back share a single RAM write port. They never
  // overlap because wr_ready is low throughout INIT.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = wr_addr;
    w_mem_wdata = wr_data;
    if (rst_n) begin
      if (r_state == S_INIT) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = r_clr_ptr;
        w_mem_wdata = '0;
      end else if (w_wr_keep) begin
        w_mem_we    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports. Priority: hardwired zero, then same-edge write bypass, then
  // the array. w_wr_keep already excludes the discarded write to entry 0.
  // ---------------------------------------------------------------------------
  assign w_rd_addr[0] = rd_addr1;
  assign w_rd_addr[1] = rd_addr2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      always_comb begin
        w_rd_data[gi] = r_mem[w_rd_addr[gi]];
        if (ZERO_EN && (w_rd_addr[gi] == '0)) begin
          w_rd_data[gi] = '0;
        end else if (w_wr_keep && (wr_addr == w_rd_addr[gi])) begin
          w_rd_data[gi] = wr_data;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_q[gi] <= '0;
        end else if (rd_en && (r_state == S_RUN)) begin
          r_q[gi] <= w_rd_data[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en && (r_state == S_RUN);
    end
  end

  assign q1       = r_q[0];
  assign q2       = r_q[1];
  assign rd_valid = r_rd_valid;

endmodule
